ext_mailbox: RTL and testbench

- Memory-mapped byte mailbox. It is a bus responder on the external page-3 interface of the 6502 SoC.
- CPU writes bytes into a TX FIFO, which drains to an external host over a valid/ready stream.
- The host pushes bytes into an RX FIFO, which the CPU reads.
- A level IRQ output can share the CPU IRQ line.

---
 rtl/ext_mailbox_pkg.sv | 35 +++
 rtl/mbox_fifo.sv | 67 ++++++
 rtl/ext_mailbox.sv | 127 ++++++++++++
 tb/tb_ext_mailbox.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_mailbox_pkg.sv
// Shared constants for the external byte mailbox: register offsets,
// STAT/IEN bit positions, the decoded CPU write strobes and a count helper.
package ext_mailbox_pkg;

  // Register offsets (CPU_AB[1:0])
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_IEN  = 2'd2;
  localparam logic [1:0] REG_CNT  = 2'd3;

  // STAT bit positions
  localparam int STAT_RX_NOT_EMPTY = 0;  // read; write 1 pops RX
  localparam int STAT_TX_NOT_FULL  = 1;
  localparam int STAT_TX_EMPTY     = 2;
  localparam int STAT_TX_OVF       = 3;  // read; write 1 clears
  localparam int STAT_IRQ          = 7;

  // IEN bit positions
  localparam int IEN_RX  = 0;
  localparam int IEN_TXE = 1;

  // One-hot-ish decode of a CPU write cycle
  typedef struct packed {
    logic tx_push;
    logic rx_pop;
    logic ovf_clr;
    logic ien_wr;
  } wr_strobe_t;

  // Clamp an occupancy count into the 4-bit CNT nibble
  function automatic logic [3:0] sat_nibble(input int c);
    return (c > 15) ? 4'hF : 4'(c);
  endfunction

endpackage

// File: rtl/mbox_fifo.sv
// Byte FIFO with first-word-fall-through read port. A push while full is
// accepted only when a pop happens on the same edge; a pop while empty is
// ignored. count_next exposes the post-edge occupancy for registered flags.
module mbox_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic [AW:0]   count_next
);

  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = 1;
  localparam logic [AW-1:0] PTR_ONE    = 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty      = (count_q == '0);
  assign full       = (count_q == FULL_COUNT);
  assign count      = count_q;
  assign count_next = count_d;
  assign rdata      = mem_q[rd_ptr_q];

  // Qualify push/pop against occupancy and compute next pointers and count
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ext_mailbox.sv
// Memory-mapped byte mailbox on the 6502 external page-3 bus. The CPU
// pushes bytes into a TX FIFO drained by the host and reads bytes the host
// pushed into an RX FIFO. dout is registered every cycle from addr.
//
// Stream handshakes (both directions): a byte transfers on a rising clk
// edge where valid and ready are both high; valid must not depend on ready.
// tx_valid is simply "TX not empty" and rx_ready is "RX not full", both
// taken from pre-edge state.
module ext_mailbox
  import ext_mailbox_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);

  wr_strobe_t  strobe;
  logic        tx_pop, rx_push;
  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic [7:0]  rx_head;
  logic [AW:0] tx_count, tx_count_next, rx_count, rx_count_next;

  logic [7:0]  dout_q, dout_d;
  logic        irq_q, irq_d;
  logic        tx_ovf_q, tx_ovf_d;
  logic [1:0]  irq_en_q, irq_en_d;

  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_push  = rx_valid & rx_ready;
  assign dout     = dout_q;
  assign irq      = irq_q;

  mbox_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (strobe.tx_push),
    .pop        (tx_pop),
    .wdata      (din),
    .rdata      (tx_data),
    .empty      (tx_empty),
    .full       (tx_full),
    .count      (tx_count),
    .count_next (tx_count_next)
  );

  mbox_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (rx_push),
    .pop        (strobe.rx_pop),
    .wdata      (rx_data),
    .rdata      (rx_head),
    .empty      (rx_empty),
    .full       (rx_full),
    .count      (rx_count),
    .count_next (rx_count_next)
  );

  // Decode CPU write cycles into per-register strobes
  always_comb begin
    strobe         = '0;
    strobe.tx_push = cs & we & (addr == REG_DATA);
    strobe.rx_pop  = cs & we & (addr == REG_STAT) & din[STAT_RX_NOT_EMPTY];
    strobe.ovf_clr = cs & we & (addr == REG_STAT) & din[STAT_TX_OVF];
    strobe.ien_wr  = cs & we & (addr == REG_IEN);
  end

  // Next-state for the sticky overflow flag, interrupt enables and irq;
  // a fresh overflow outranks a clear on the same edge
  always_comb begin
    tx_ovf_d = (tx_ovf_q & ~strobe.ovf_clr) |
               (strobe.tx_push & tx_full & ~tx_pop);
    irq_en_d = strobe.ien_wr ? din[1:0] : irq_en_q;
    irq_d    = (irq_en_d[IEN_RX]  & (rx_count_next != '0)) |
               (irq_en_d[IEN_TXE] & (tx_count_next == '0));
  end

  // Read mux from pre-edge state; reads have no side effects
  always_comb begin
    dout_d = '0;
    case (addr)
      REG_DATA: dout_d = rx_empty ? 8'h00 : rx_head;
      REG_STAT: begin
        dout_d[STAT_RX_NOT_EMPTY] = ~rx_empty;
        dout_d[STAT_TX_NOT_FULL]  = ~tx_full;
        dout_d[STAT_TX_EMPTY]     = tx_empty;
        dout_d[STAT_TX_OVF]       = tx_ovf_q;
        dout_d[STAT_IRQ]          = irq_q;
      end
      REG_IEN:  dout_d = {6'b0, irq_en_q};
      REG_CNT:  dout_d = {sat_nibble(int'(rx_count)), sat_nibble(int'(tx_count))};
      default:  dout_d = '0;
    endcase
  end

  // Control and read-data registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q   <= '0;
      irq_q    <= 1'b0;
      tx_ovf_q <= 1'b0;
      irq_en_q <= '0;
    end else begin
      dout_q   <= dout_d;
      irq_q    <= irq_d;
      tx_ovf_q <= tx_ovf_d;
      irq_en_q <= irq_en_d;
    end
  end

endmodule

// File: tb/tb_ext_mailbox.sv
// Bench for ext_mailbox: a queue-based model of the mailbox checked against
// the DUT on every falling edge, plus directed scenarios with literal values.
module tb_ext_mailbox;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cs = 1'b0;
  logic       we = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       irq;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  int errors = 0;
  int checks = 0;

  // Clock
  always #5 clk = ~clk;

  ext_mailbox #(.DEPTH(16), .AW(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .we       (we),
    .addr     (addr),
    .din      (din),
    .dout     (dout),
    .irq      (irq),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  // Host RX source: offers rx_src[rx_idx] while rx_idx < rx_lim
  logic [7:0] rx_src [32];
  int rx_idx = 0;
  int rx_lim = 0;
  assign rx_valid = (rx_idx < rx_lim);
  assign rx_data  = rx_src[rx_idx[4:0]];

  // Model state
  logic [7:0] m_tx_q[$];
  logic [7:0] m_rx_q[$];
  logic [7:0] host_log[$];
  logic       m_ovf = 1'b0;
  logic [1:0] m_ien = 2'b00;
  logic       m_irq = 1'b0;
  logic [7:0] m_dout = 8'h00;

  function automatic logic [3:0] sat4(input int n);
    return (n > 15) ? 4'hF : 4'(n);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: advances on each rising edge from pre-edge inputs and state
  initial begin
    bit wr, t_pop, r_push, r_pop, tx_full_pre;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_tx_q.delete();
        m_rx_q.delete();
        m_ovf  = 1'b0;
        m_ien  = 2'b00;
        m_irq  = 1'b0;
        m_dout = 8'h00;
      end else begin
        if (tx_valid && tx_ready) host_log.push_back(tx_data);
        if (rx_valid && rx_ready) rx_idx <= rx_idx + 1;
        wr = cs && we;
        case (addr)
          2'd0: m_dout = (m_rx_q.size() > 0) ? m_rx_q[0] : 8'h00;
          2'd1: m_dout = {m_irq, 3'b000, m_ovf, (m_tx_q.size() == 0),
                          (m_tx_q.size() < DEPTH), (m_rx_q.size() > 0)};
          2'd2: m_dout = {6'b0, m_ien};
          default: m_dout = {sat4(m_rx_q.size()), sat4(m_tx_q.size())};
        endcase
        tx_full_pre = (m_tx_q.size() == DEPTH);
        t_pop  = tx_ready && (m_tx_q.size() > 0);
        r_push = rx_valid && (m_rx_q.size() < DEPTH);
        r_pop  = wr && (addr == 2'd1) && din[0] && (m_rx_q.size() > 0);
        if (t_pop) void'(m_tx_q.pop_front());
        if (r_pop) void'(m_rx_q.pop_front());
        if (r_push) m_rx_q.push_back(rx_data);
        if (wr && addr == 2'd1 && din[3]) m_ovf = 1'b0;
        if (wr && addr == 2'd0) begin
          if (!tx_full_pre || t_pop) m_tx_q.push_back(din);
          else m_ovf = 1'b1;
        end
        if (wr && addr == 2'd2) m_ien = din[1:0];
        m_irq = (m_ien[0] && m_rx_q.size() > 0) || (m_ien[1] && m_tx_q.size() == 0);
      end
    end
  end

  // Compare DUT outputs with the model every falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("tx_valid", {7'b0, tx_valid}, {7'b0, (m_tx_q.size() > 0)});
        if (m_tx_q.size() > 0) chk("tx_data", tx_data, m_tx_q[0]);
        chk("rx_ready", {7'b0, rx_ready}, {7'b0, (m_rx_q.size() < DEPTH)});
        chk("irq", {7'b0, irq}, {7'b0, m_irq});
        chk("dout", dout, m_dout);
      end
    end
  end

  // Driver tasks: each starts and ends 1 time unit after a rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    step();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic cpu_rd(input logic [1:0] a, output logic [7:0] d);
    cs = 1'b1; we = 1'b0; addr = a;
    step();
    d = dout;
    cs = 1'b0;
  endtask

  // Host must have received exactly base, base+1, ... base+n-1
  task automatic check_log(input string name, input logic [7:0] base, input int n);
    logic [7:0] exp_b;
    chk({name, "_len"}, 8'(host_log.size()), 8'(n));
    for (int i = 0; i < n; i++) begin
      exp_b = base + 8'(i);
      chk(name, (i < host_log.size()) ? host_log[i] : ~exp_b, exp_b);
    end
  endtask

  // Directed scenarios
  initial begin
    logic [7:0] rd;
    for (int i = 0; i < 32; i++) rx_src[i] = 8'h00;
    for (int i = 0; i < 17; i++) rx_src[i] = 8'hA0 + 8'(i);
    rx_src[17] = 8'hC0;
    rx_src[18] = 8'h55;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_dout", dout, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("rst_rx_ready", {7'b0, rx_ready}, 8'h01);

    // TX path
    tx_ready = 1'b0;
    cpu_wr(2'd0, 8'h41);
    cpu_wr(2'd0, 8'h42);
    cpu_rd(2'd3, rd);
    chk("tx_cnt", rd, 8'h02);
    chk("tx_head", tx_data, 8'h41);
    host_log.delete();
    tx_ready = 1'b1;
    idle(4);
    check_log("tx_host", 8'h41, 2);
    cpu_rd(2'd1, rd);
    chk("tx_stat_empty", rd, 8'h06);

    // TX overflow
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) cpu_wr(2'd0, 8'(i));
    cpu_rd(2'd1, rd);
    chk("ovf_stat", rd, 8'h08);
    cpu_rd(2'd3, rd);
    chk("ovf_cnt", rd, 8'h0F);
    host_log.delete();
    tx_ready = 1'b1;
    idle(18);
    check_log("ovf_drain", 8'h00, 16);
    cpu_wr(2'd1, 8'h08);
    cpu_rd(2'd1, rd);
    chk("ovf_clear", rd, 8'h06);

    // TX full with a write on the same edge as a host pop
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) cpu_wr(2'd0, 8'h20 + 8'(i));
    host_log.delete();
    tx_ready = 1'b1;
    cpu_wr(2'd0, 8'h30);
    idle(18);
    check_log("tx_sim", 8'h20, 17);
    cpu_rd(2'd1, rd);
    chk("tx_sim_stat", rd, 8'h06);

    // Reset asserted between edges while TX holds data
    cpu_wr(2'd2, 8'h02);
    tx_ready = 1'b0;
    cpu_wr(2'd0, 8'h01);
    cpu_wr(2'd0, 8'h02);
    cpu_wr(2'd0, 8'h03);
    #2 reset = 1'b1;
    #1;
    chk("arst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("arst_irq", {7'b0, irq}, 8'h00);
    chk("arst_rx_ready", {7'b0, rx_ready}, 8'h01);
    chk("arst_dout", dout, 8'h00);
    @(posedge clk);
    #1 reset = 1'b0;
    cpu_rd(2'd3, rd);
    chk("arst_cnt", rd, 8'h00);
    cpu_rd(2'd2, rd);
    chk("arst_ien", rd, 8'h00);

    // RX path until full
    rx_lim = 17;
    idle(20);
    chk("rx_full_ready", {7'b0, rx_ready}, 8'h00);
    chk("rx_taken", 8'(rx_idx), 8'd16);
    cpu_rd(2'd0, rd);
    chk("rx_head", rd, 8'hA0);
    cpu_rd(2'd0, rd);
    chk("rx_reread", rd, 8'hA0);
    cpu_rd(2'd3, rd);
    chk("rx_cnt", rd, 8'hF0);
    cpu_wr(2'd1, 8'h01);
    cpu_rd(2'd0, rd);
    chk("rx_after_pop", rd, 8'hA1);
    idle(1);
    chk("rx_taken2", 8'(rx_idx), 8'd17);

    // RX full with the host offering on the pop edge
    rx_lim = 18;
    idle(2);
    chk("rx_blocked", 8'(rx_idx), 8'd17);
    cpu_wr(2'd1, 8'h01);
    idle(2);
    chk("rx_taken3", 8'(rx_idx), 8'd18);
    for (int i = 0; i < 16; i++) begin
      cpu_rd(2'd0, rd);
      chk("rx_drain", rd, (i < 15) ? (8'hA2 + 8'(i)) : 8'hC0);
      cpu_wr(2'd1, 8'h01);
    end
    cpu_rd(2'd3, rd);
    chk("rx_drain_cnt", rd, 8'h00);

    // IRQ behaviour
    cpu_wr(2'd2, 8'h01);
    rx_lim = 19;
    step();
    chk("irq_rx_set", {7'b0, irq}, 8'h01);
    cpu_wr(2'd1, 8'h01);
    chk("irq_rx_clr", {7'b0, irq}, 8'h00);
    cpu_wr(2'd2, 8'h02);
    chk("irq_txe_set", {7'b0, irq}, 8'h01);
    tx_ready = 1'b0;
    cpu_wr(2'd0, 8'h77);
    chk("irq_txe_clr", {7'b0, irq}, 8'h00);
    tx_ready = 1'b1;
    idle(3);
    cpu_rd(2'd1, rd);
    chk("irq_stat", rd, 8'h86);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
